lockin_sequencer: RTL and testbench
===================================

Name: lockin_sequencer

Overview:
- Per-sample scheduler for the lock-in datapath: front FIR stage (Hilbert + delay lines) → product register → lock-in low-pass pair.
- On each sample tick, launches the front stage and waits for both front done flags. It then enables the product register, launches both LPFs, waits for both LPF done flags, and emits one result strobe.
- Detects ticks that arrive while a sample is in flight (overrun) and, optionally, stalled stages (watchdog).

Parameters:
- CNT_W, 32, width of sample and overrun counters.
- WDOG_CYCLES, 4096, max cycles allowed in one wait state before abort (watchdog builds only).

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  synchronous, active-high reset.
- tick_i  in  1  new-sample strobe, one cycle.
- front_start_o  out  1  one-cycle launch to Hilbert + delay FIRs.
- hilbert_done_i  in  1  Hilbert FIR finished.
- delay_done_i  in  1  delay-line FIRs finished (ch1 and ch2 paths are in lockstep).
- mult_en_o  out  1  one-cycle load enable for the product registers.
- lpf_start_o  out  1  one-cycle launch to both LPFs.
- lpf_x_done_i  in  1  X low-pass finished.
- lpf_y_done_i  in  1  Y low-pass finished.
- done_o  out  1  one-cycle strobe: x/y outputs valid.
- busy_o  out  1  sample in flight.
- status_clr_i  in  1  clears overrun/fault status.
- overrun_o  out  1  sticky: tick dropped.
- overrun_cnt_o  out  CNT_W  saturating count of dropped ticks.
- sample_cnt_o  out  CNT_W  completed samples, wraps.
- fault_o  out  1  sticky watchdog abort (constant 0 without macro).

Behaviour:
- All outputs are registered.
- Reset: state IDLE, all strobes 0, busy_o 0, overrun_o 0, fault_o 0, both counters 0, sticky done flags 0.
- Reset mid-operation aborts immediately, with no done_o.
- States:
  - IDLE
  - FRONT (wait front dones)
  - MULT
  - BACK (wait LPF dones)
  - DONE
- IDLE: tick_i at cycle T → FRONT, front_start_o=1 in cycle T+1; both front sticky flags cleared.
- FRONT:
  - hilbert_done_i and delay_done_i are each captured into a sticky flag; they may arrive in any order or the same cycle.
  - Dones are ignored in the cycle front_start_o is high.
  - Cycle after both flags are set (or both inputs high) → MULT.
- MULT: mult_en_o=1 for exactly this cycle; next state BACK with lpf_start_o=1 in its first cycle; LPF sticky flags cleared.
- BACK: same sticky/ignore rules as FRONT for lpf_x_done_i and lpf_y_done_i; when both are seen → DONE.
- DONE: done_o=1, sample_cnt_o increments (wraps at 2^CNT_W).
  - tick_i in DONE is accepted as in IDLE (back-to-back samples).
  - Otherwise → IDLE.
- Minimum latency, tick to done_o: 6 cycles when every done returns the cycle after its start.
- busy_o=1 in FRONT, MULT and BACK.
- Overrun: tick_i in FRONT, MULT or BACK is dropped; overrun_o←1; overrun_cnt_o+1, saturating at all-ones. The current sample continues unaffected.
- status_clr_i clears overrun_o, overrun_cnt_o and fault_o.
  - Simultaneous clear and new overrun: the overrun wins (overrun_o=1, count=1).
  - Simultaneous clear and fault: the fault wins.
- Done inputs seen in IDLE or DONE are ignored.

Optional Feature:
- LOCKIN_SEQ_WATCHDOG_EN defined:
  - A cycle counter runs in FRONT and BACK and resets on each state entry.
  - When it reaches WDOG_CYCLES-1 without completion: fault_o←1 (sticky), state→IDLE, no mult_en_o/lpf_start_o/done_o, sample_cnt_o unchanged.
  - A tick in the abort cycle counts as an overrun.
- Undefined: no counter, fault_o tied 0, wait states wait indefinitely.

Decomposition:
- Package lockin_seq_pkg: state enum (IDLE, FRONT, MULT, BACK, DONE), default CNT_W, default WDOG_CYCLES.
- One sub-module, lockin_seq_watchdog: load/enable counter with expiry flag, instantiated only under the macro.

Test Plan:
1. Reset, tick at cycle 10, each done returned 1 cycle after its start → front_start_o@11, mult_en_o@13, lpf_start_o@14, done_o@16, sample_cnt_o=1.
2. hilbert_done_i 5 cycles after start, delay_done_i 20 cycles after start → MULT only after the later done; exactly one mult_en_o pulse; done_o once.
3. Three extra ticks during BACK → overrun_o=1, overrun_cnt_o=3, sample completes normally. Then status_clr_i coincident with a fourth overrun tick → overrun_o=1, overrun_cnt_o=1.
4. Tick in the DONE cycle → front_start_o the next cycle, no overrun; 1000 back-to-back samples → sample_cnt_o=1000, overrun_cnt_o=0.
5. reset_i asserted while in BACK → next cycle all outputs at reset values; a later late lpf_x_done_i pulse produces no done_o.
6. With LOCKIN_SEQ_WATCHDOG_EN and WDOG_CYCLES=16, lpf_y_done_i never asserted → fault_o=1 after 16 cycles in BACK, state IDLE, no done_o; the next tick runs normally.

Source files
------------

// File: rtl/lockin_seq_pkg.sv
// Shared state encoding and parameter defaults for the lock-in sample sequencer.
package lockin_seq_pkg;

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_FRONT = 3'd1,
    SEQ_MULT  = 3'd2,
    SEQ_BACK  = 3'd3,
    SEQ_DONE  = 3'd4
  } seq_state_e;

  localparam int SEQ_CNT_W_DEF       = 32;
  localparam int SEQ_WDOG_CYCLES_DEF = 4096;

  // Counter width able to hold 0 .. cycles-1 with one spare bit.
  function automatic int seq_wdog_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/lockin_seq_watchdog.sv
// Stall timer for the sequencer wait states; only present when LOCKIN_SEQ_WATCHDOG_EN is defined.
// Held at zero while load_i is high, counts while en_i is high, and stops at CYCLES-1.
`ifdef LOCKIN_SEQ_WATCHDOG_EN
module lockin_seq_watchdog
  import lockin_seq_pkg::*;
#(
  parameter int CYCLES = SEQ_WDOG_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = seq_wdog_width(CYCLES);

  logic [CW-1:0] r_cnt;
  logic          w_at_limit;

  assign w_at_limit = (r_cnt == CW'(CYCLES - 1));
  assign expired_o  = w_at_limit;

  always_ff @(posedge clk_i) begin
    if (reset_i || load_i) begin
      r_cnt <= '0;
    end else if (en_i && !w_at_limit) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule
`endif

// File: rtl/lockin_sequencer.sv
// Per-sample scheduler: front FIRs -> product register -> LPF pair, with overrun accounting.
// Define LOCKIN_SEQ_WATCHDOG_EN to add the wait-state watchdog (fault_o, WDOG_CYCLES).
module lockin_sequencer
  import lockin_seq_pkg::*;
#(
  parameter int CNT_W = SEQ_CNT_W_DEF
`ifdef LOCKIN_SEQ_WATCHDOG_EN
  ,
  parameter int WDOG_CYCLES = SEQ_WDOG_CYCLES_DEF
`endif
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             tick_i,
  output logic             front_start_o,
  input  logic             hilbert_done_i,
  input  logic             delay_done_i,
  output logic             mult_en_o,
  output logic             lpf_start_o,
  input  logic             lpf_x_done_i,
  input  logic             lpf_y_done_i,
  output logic             done_o,
  output logic             busy_o,
  input  logic             status_clr_i,
  output logic             overrun_o,
  output logic [CNT_W-1:0] overrun_cnt_o,
  output logic [CNT_W-1:0] sample_cnt_o,
  output logic             fault_o
);

  localparam logic [2:0] ST_IDLE  = SEQ_IDLE;
  localparam logic [2:0] ST_FRONT = SEQ_FRONT;
  localparam logic [2:0] ST_MULT  = SEQ_MULT;
  localparam logic [2:0] ST_BACK  = SEQ_BACK;
  localparam logic [2:0] ST_DONE  = SEQ_DONE;

  logic [2:0]       r_state;
  logic             r_front_start, r_mult_en, r_lpf_start, r_done, r_busy;
  logic             r_hil_seen, r_dly_seen, r_x_seen, r_y_seen;
  logic             r_overrun, r_fault;
  logic [CNT_W-1:0] r_overrun_cnt, r_sample_cnt;

  logic w_in_wait, w_in_flight, w_drop;
  logic w_front_ok, w_back_ok, w_stage_ok, w_abort, w_wdog_expired;

  assign w_in_wait   = (r_state == ST_FRONT) || (r_state == ST_BACK);
  assign w_in_flight = w_in_wait || (r_state == ST_MULT);
  assign w_drop      = tick_i && w_in_flight;

  // A done coinciding with its own launch strobe is stale and must not count.
  assign w_front_ok = !r_front_start && (r_hil_seen || hilbert_done_i)
                                     && (r_dly_seen || delay_done_i);
  assign w_back_ok  = !r_lpf_start && (r_x_seen || lpf_x_done_i)
                                   && (r_y_seen || lpf_y_done_i);
  assign w_stage_ok = (r_state == ST_FRONT) ? w_front_ok : w_back_ok;
  assign w_abort    = w_wdog_expired && w_in_wait && !w_stage_ok;

`ifdef LOCKIN_SEQ_WATCHDOG_EN
  lockin_seq_watchdog #(
    .CYCLES (WDOG_CYCLES)
  ) u_watchdog (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .load_i    (!w_in_wait),
    .en_i      (w_in_wait),
    .expired_o (w_wdog_expired)
  );
`else
  assign w_wdog_expired = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state       <= ST_IDLE;
      r_front_start <= 1'b0;
      r_mult_en     <= 1'b0;
      r_lpf_start   <= 1'b0;
      r_done        <= 1'b0;
      r_busy        <= 1'b0;
      r_hil_seen    <= 1'b0;
      r_dly_seen    <= 1'b0;
      r_x_seen      <= 1'b0;
      r_y_seen      <= 1'b0;
      r_overrun     <= 1'b0;
      r_fault       <= 1'b0;
      r_overrun_cnt <= '0;
      r_sample_cnt  <= '0;
    end else begin
      r_front_start <= 1'b0;
      r_mult_en     <= 1'b0;
      r_lpf_start   <= 1'b0;
      r_done        <= 1'b0;

      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (tick_i) begin
            r_state       <= ST_FRONT;
            r_front_start <= 1'b1;
            r_busy        <= 1'b1;
            r_hil_seen    <= 1'b0;
            r_dly_seen    <= 1'b0;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_FRONT: begin
          if (!r_front_start) begin
            r_hil_seen <= r_hil_seen | hilbert_done_i;
            r_dly_seen <= r_dly_seen | delay_done_i;
          end
          if (w_front_ok) begin
            r_state   <= ST_MULT;
            r_mult_en <= 1'b1;
          end else if (w_abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_MULT: begin
          r_state     <= ST_BACK;
          r_lpf_start <= 1'b1;
          r_x_seen    <= 1'b0;
          r_y_seen    <= 1'b0;
        end
        ST_BACK: begin
          if (!r_lpf_start) begin
            r_x_seen <= r_x_seen | lpf_x_done_i;
            r_y_seen <= r_y_seen | lpf_y_done_i;
          end
          if (w_back_ok) begin
            r_state      <= ST_DONE;
            r_done       <= 1'b1;
            r_busy       <= 1'b0;
            r_sample_cnt <= r_sample_cnt + CNT_W'(1);
          end else if (w_abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      // A dropped tick takes priority over a coincident status clear.
      if (w_drop) begin
        r_overrun <= 1'b1;
        if (status_clr_i) begin
          r_overrun_cnt <= CNT_W'(1);
        end else if (r_overrun_cnt != '1) begin
          r_overrun_cnt <= r_overrun_cnt + CNT_W'(1);
        end
      end else if (status_clr_i) begin
        r_overrun     <= 1'b0;
        r_overrun_cnt <= '0;
      end

      if (w_abort) begin
        r_fault <= 1'b1;
      end else if (status_clr_i) begin
        r_fault <= 1'b0;
      end
    end
  end

  assign front_start_o = r_front_start;
  assign mult_en_o     = r_mult_en;
  assign lpf_start_o   = r_lpf_start;
  assign done_o        = r_done;
  assign busy_o        = r_busy;
  assign overrun_o     = r_overrun;
  assign overrun_cnt_o = r_overrun_cnt;
  assign sample_cnt_o  = r_sample_cnt;
  assign fault_o       = r_fault;

endmodule

// File: tb/tb_lockin_sequencer.sv
// Bench for lockin_sequencer: directed vector table, hand-written corner sequences and a
// randomized run checked against a per-sample timing schedule computed in the bench.
`timescale 1ns/1ps
module tb_lockin_sequencer;

  localparam int CNT_W    = 32;
  localparam int PLAN_MAX = 8000;

  // Bit order (MSB first): tick hd dd xd yd | fs me ls dn busy
  typedef struct packed {
    logic tick; logic hd; logic dd; logic xd; logic yd;
    logic fs;   logic me; logic ls; logic dn; logic busy;
  } vec_t;

  logic clk_i          = 1'b0;
  logic reset_i        = 1'b1;
  logic tick_i         = 1'b0;
  logic hilbert_done_i = 1'b0;
  logic delay_done_i   = 1'b0;
  logic lpf_x_done_i   = 1'b0;
  logic lpf_y_done_i   = 1'b0;
  logic status_clr_i   = 1'b0;
  logic front_start_o, mult_en_o, lpf_start_o, done_o, busy_o, overrun_o, fault_o;
  logic [CNT_W-1:0] overrun_cnt_o, sample_cnt_o;

  int   checks   = 0;
  int   failures = 0;
  vec_t tbl1 [18];
  vec_t plan [];
  int   rw_n_me, rw_me_at, rw_n_dn, rw_dn_at, rw_fault_at;

  always #5 clk_i = ~clk_i;

  lockin_sequencer #(
    .CNT_W (CNT_W)
`ifdef LOCKIN_SEQ_WATCHDOG_EN
    ,
    .WDOG_CYCLES (16)
`endif
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .tick_i         (tick_i),
    .front_start_o  (front_start_o),
    .hilbert_done_i (hilbert_done_i),
    .delay_done_i   (delay_done_i),
    .mult_en_o      (mult_en_o),
    .lpf_start_o    (lpf_start_o),
    .lpf_x_done_i   (lpf_x_done_i),
    .lpf_y_done_i   (lpf_y_done_i),
    .done_o         (done_o),
    .busy_o         (busy_o),
    .status_clr_i   (status_clr_i),
    .overrun_o      (overrun_o),
    .overrun_cnt_o  (overrun_cnt_o),
    .sample_cnt_o   (sample_cnt_o),
    .fault_o        (fault_o)
  );

  always @(negedge clk_i) begin
    if (done_o) $display("txn: sample done at %0t, sample_cnt=%0d", $time, sample_cnt_o);
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic clear_inputs();
    tick_i = 1'b0; hilbert_done_i = 1'b0; delay_done_i = 1'b0;
    lpf_x_done_i = 1'b0; lpf_y_done_i = 1'b0; status_clr_i = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_i = 1'b1;
    step();
    step();
    reset_i = 1'b0;
  endtask

  // Outputs of the current cycle are compared before that cycle's inputs are driven.
  task automatic apply_vec(input vec_t v, input string tag);
    check(tag, 64'({front_start_o, mult_en_o, lpf_start_o, done_o, busy_o}),
               64'({v.fs, v.me, v.ls, v.dn, v.busy}));
    tick_i = v.tick; hilbert_done_i = v.hd; delay_done_i = v.dd;
    lpf_x_done_i = v.xd; lpf_y_done_i = v.yd;
    step();
  endtask

  // Reactive stage model: each done pulses a fixed delay after its launch (0 = never).
  task automatic run_window(input int dh, input int ddl, input int dx, input int dy,
                            input int ncyc, input logic [63:0] tick_mask,
                            input logic [63:0] clr_mask);
    int fs_k = -1000;
    int ls_k = -1000;
    rw_n_me = 0; rw_me_at = -1; rw_n_dn = 0; rw_dn_at = -1; rw_fault_at = -1;
    for (int k = 0; k < ncyc; k++) begin
      if (front_start_o) fs_k = k;
      if (lpf_start_o)   ls_k = k;
      if (mult_en_o) begin rw_n_me++; rw_me_at = k; end
      if (done_o)    begin rw_n_dn++; rw_dn_at = k; end
      if (fault_o && rw_fault_at < 0) rw_fault_at = k;
      tick_i         = tick_mask[k];
      status_clr_i   = clr_mask[k];
      hilbert_done_i = (dh  > 0) && (k == fs_k + dh);
      delay_done_i   = (ddl > 0) && (k == fs_k + ddl);
      lpf_x_done_i   = (dx  > 0) && (k == ls_k + dx);
      lpf_y_done_i   = (dy  > 0) && (k == ls_k + dy);
      step();
    end
    clear_inputs();
  endtask

  // Timing schedule from the sample rules: start = tick+1, product one cycle after the
  // later front done, LPF launch next, done one cycle after the later LPF done.
  task automatic build_plan(input bit rnd, input int ns, output int len, output int exp_ovr);
    int t, fs, me, ls, dn, d_h, d_d, d_x, d_y, gap, n, c;
    plan = new[PLAN_MAX];
    foreach (plan[i]) plan[i] = '0;
    t = 2; dn = 0; exp_ovr = 0;
    for (int s = 0; s < ns; s++) begin
      d_h = rnd ? int'($urandom_range(1, 6)) : 1;
      d_d = rnd ? int'($urandom_range(1, 6)) : 1;
      d_x = rnd ? int'($urandom_range(1, 6)) : 1;
      d_y = rnd ? int'($urandom_range(1, 6)) : 1;
      fs = t + 1;
      me = fs + max2(d_h, d_d) + 1;
      ls = me + 1;
      if (ls + max2(d_x, d_y) + 4 >= PLAN_MAX) break;
      dn = ls + max2(d_x, d_y) + 1;
      plan[t].tick = 1'b1;
      plan[fs].fs = 1'b1;
      plan[fs + d_h].hd = 1'b1;
      plan[fs + d_d].dd = 1'b1;
      plan[me].me = 1'b1;
      plan[ls].ls = 1'b1;
      plan[ls + d_x].xd = 1'b1;
      plan[ls + d_y].yd = 1'b1;
      plan[dn].dn = 1'b1;
      for (int k = fs; k < dn; k++) plan[k].busy = 1'b1;
      gap = 0;
      if (rnd) begin
        n = int'($urandom_range(0, 2));
        for (int k = 0; k < n; k++) begin
          c = int'($urandom_range(fs, dn - 1));
          if (!plan[c].tick) begin
            plan[c].tick = 1'b1;
            exp_ovr++;
          end
        end
        if ($urandom_range(0, 1) == 1) begin plan[fs].hd = 1'b1; plan[fs].dd = 1'b1; end
        if ($urandom_range(0, 1) == 1) begin plan[ls].xd = 1'b1; plan[ls].yd = 1'b1; end
        {plan[dn].hd, plan[dn].dd, plan[dn].xd, plan[dn].yd} = 4'($urandom_range(0, 15));
        {plan[dn+1].hd, plan[dn+1].dd, plan[dn+1].xd, plan[dn+1].yd} = 4'($urandom_range(0, 15));
        gap = int'($urandom_range(0, 3));
      end
      t = dn + gap;
    end
    len = dn + 3;
  endtask

  initial begin
    int len, exp_ovr, n_dn;

    // Sample 1 table: tick at cycle 10, every done one cycle after its launch; stale
    // dones in IDLE and in the launch cycles must be ignored.
    tbl1 = '{default: '0};
    tbl1[3]  = 10'b01111_00000;
    tbl1[10] = 10'b10000_00000;
    tbl1[11] = 10'b01100_10001;
    tbl1[12] = 10'b01100_00001;
    tbl1[13] = 10'b00000_01001;
    tbl1[14] = 10'b00011_00101;
    tbl1[15] = 10'b00011_00001;
    tbl1[16] = 10'b00000_00010;

    do_reset();
    check("rst_strobes", 64'({front_start_o, mult_en_o, lpf_start_o, done_o}), 64'(0));
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_overrun", 64'(overrun_o), 64'(0));
    check("rst_fault", 64'(fault_o), 64'(0));
    check("rst_overrun_cnt", 64'(overrun_cnt_o), 64'(0));
    check("rst_sample_cnt", 64'(sample_cnt_o), 64'(0));

    for (int i = 0; i < 18; i++) apply_vec(tbl1[i], $sformatf("t1_cycle%0d", i));
    check("t1_sample_cnt", 64'(sample_cnt_o), 64'(1));
    check("t1_overrun", 64'(overrun_o), 64'(0));

    // Uneven front dones: 5 and 20 cycles after the launch at k=1.
    do_reset();
    run_window(5, 20, 1, 1, 40, 64'h1, 64'h0);
    check("t2_mult_count", 64'(rw_n_me), 64'(1));
    check("t2_mult_at", 64'(rw_me_at), 64'(1 + 20 + 1));
    check("t2_done_count", 64'(rw_n_dn), 64'(1));
    check("t2_done_at", 64'(rw_dn_at), 64'(1 + 20 + 1 + 1 + 1 + 1));

    // Three ticks during BACK (cycles 4..14), then clear coincident with a fresh overrun.
    do_reset();
    run_window(1, 1, 10, 10, 20, 64'h541, 64'h0);
    check("t3_done_at", 64'(rw_dn_at), 64'(15));
    check("t3_done_count", 64'(rw_n_dn), 64'(1));
    check("t3_overrun", 64'(overrun_o), 64'(1));
    check("t3_overrun_cnt", 64'(overrun_cnt_o), 64'(3));
    run_window(1, 1, 1, 1, 10, 64'h5, 64'h4);
    check("t3_clr_overrun", 64'(overrun_o), 64'(1));
    check("t3_clr_overrun_cnt", 64'(overrun_cnt_o), 64'(1));
    check("t3_sample_cnt", 64'(sample_cnt_o), 64'(2));
    status_clr_i = 1'b1;
    step();
    status_clr_i = 1'b0;
    check("t3_plain_clr", 64'({overrun_o, overrun_cnt_o}), 64'(0));

    // Randomized samples against the schedule model.
    do_reset();
    build_plan(1'b1, 200, len, exp_ovr);
    for (int i = 0; i < len; i++) apply_vec(plan[i], "rand_strobes");
    check("rand_sample_cnt", 64'(sample_cnt_o), 64'(200));
    check("rand_overrun_cnt", 64'(overrun_cnt_o), 64'(exp_ovr));
    check("rand_overrun", 64'(overrun_o), 64'(exp_ovr > 0));

    // 1000 back-to-back samples, each new tick landing in the DONE cycle.
    do_reset();
    build_plan(1'b0, 1000, len, exp_ovr);
    for (int i = 0; i < len; i++) apply_vec(plan[i], "b2b_strobes");
    check("b2b_sample_cnt", 64'(sample_cnt_o), 64'(1000));
    check("b2b_overrun_cnt", 64'(overrun_cnt_o), 64'(0));

    // Reset while in BACK, then late LPF dones must not produce done_o.
    do_reset();
    run_window(1, 1, 0, 0, 12, 64'h41, 64'h0);
    check("t5_busy_pre", 64'(busy_o), 64'(1));
    check("t5_overrun_pre", 64'(overrun_o), 64'(1));
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    check("t5_rst_flags", 64'({front_start_o, mult_en_o, lpf_start_o, done_o, busy_o,
                               overrun_o, fault_o}), 64'(0));
    check("t5_rst_counts", 64'({overrun_cnt_o, sample_cnt_o}), 64'(0));
    n_dn = 0;
    for (int k = 0; k < 10; k++) begin
      if (done_o) n_dn++;
      lpf_x_done_i = (k == 2);
      lpf_y_done_i = (k == 3);
      step();
    end
    clear_inputs();
    check("t5_no_done", 64'(n_dn), 64'(0));
    check("t5_idle", 64'(busy_o), 64'(0));

    // Stalled LPF Y; tick and clear both land in cycle 19 (16th cycle of BACK).
    do_reset();
    run_window(1, 1, 1, 0, 30, 64'h80001, 64'h80000);
`ifdef LOCKIN_SEQ_WATCHDOG_EN
    check("t6_fault_at", 64'(rw_fault_at), 64'(20));
    check("t6_no_done", 64'(rw_n_dn), 64'(0));
    check("t6_idle", 64'(busy_o), 64'(0));
    check("t6_fault_sticky", 64'(fault_o), 64'(1));
    check("t6_abort_tick_overrun", 64'(overrun_cnt_o), 64'(1));
    check("t6_sample_cnt", 64'(sample_cnt_o), 64'(0));
    run_window(1, 1, 1, 1, 10, 64'h1, 64'h0);
    check("t6_next_done_at", 64'(rw_dn_at), 64'(6));
    check("t6_next_sample_cnt", 64'(sample_cnt_o), 64'(1));
    check("t6_fault_kept", 64'(fault_o), 64'(1));
    status_clr_i = 1'b1;
    step();
    status_clr_i = 1'b0;
    check("t6_fault_clr", 64'(fault_o), 64'(0));
`else
    check("t6_no_fault", 64'(rw_fault_at), 64'(-1));
    check("t6_no_done", 64'(rw_n_dn), 64'(0));
    check("t6_still_busy", 64'(busy_o), 64'(1));
    check("t6_tick_overrun", 64'(overrun_cnt_o), 64'(1));
    do_reset();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
